// File: rtl/alu_seq_pkg.sv
// Shared definitions for the accumulation sequencer: lane-width codes,
// sequencer states, per-width saturation limits and a lane-wise wrap adder.
package alu_seq_pkg;

    localparam logic [1:0] W8  = 2'b00;
    localparam logic [1:0] W16 = 2'b01;
    localparam logic [1:0] W32 = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0]  SAT_MAX8  = 8'h7F;
    localparam logic [7:0]  SAT_MIN8  = 8'h80;
    localparam logic [15:0] SAT_MAX16 = 16'h7FFF;
    localparam logic [15:0] SAT_MIN16 = 16'h8000;
    localparam logic [31:0] SAT_MAX32 = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN32 = 32'h8000_0000;

    // Lane-wise modular add; carries never leave a lane. Code 2'b11 falls
    // into the 32-bit branch so it behaves exactly like W32.
    function automatic logic [31:0] wrapAdd(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [1:0]  width);
        logic [31:0] sum;
        sum = '0;
        case (width)
            W8: begin
                for (int i = 0; i < 4; i++) begin
                    sum[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8];
                end
            end
            W16: begin
                for (int i = 0; i < 2; i++) begin
                    sum[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
                end
            end
            default: begin
                sum = a + b;
            end
        endcase
        return sum;
    endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// Packed-SIMD adder: 4x8, 2x16 or 1x32 lanes with optional signed
// saturation per lane. Purely combinational.
module alu_seq_alu
    import alu_seq_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [1:0]  i_width,
    input  logic        i_sat,
    output logic [31:0] o_c
);

    logic [31:0] w_wrap;

    assign w_wrap = wrapAdd(i_a, i_b, i_width);

    // Start from the wrapped sum and clamp any lane whose operands share a
    // sign that the sum does not (signed overflow) when saturation is on.
    always_comb begin
        o_c = w_wrap;
        if (i_sat) begin
            case (i_width)
                W8: begin
                    for (int i = 0; i < 4; i++) begin
                        if ((i_a[i*8+7] == i_b[i*8+7]) && (w_wrap[i*8+7] != i_a[i*8+7])) begin
                            o_c[i*8 +: 8] = i_a[i*8+7] ? SAT_MIN8 : SAT_MAX8;
                        end
                    end
                end
                W16: begin
                    for (int i = 0; i < 2; i++) begin
                        if ((i_a[i*16+15] == i_b[i*16+15]) && (w_wrap[i*16+15] != i_a[i*16+15])) begin
                            o_c[i*16 +: 16] = i_a[i*16+15] ? SAT_MIN16 : SAT_MAX16;
                        end
                    end
                end
                default: begin
                    if ((i_a[31] == i_b[31]) && (w_wrap[31] != i_a[31])) begin
                        o_c = i_a[31] ? SAT_MIN32 : SAT_MAX32;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Accumulation sequencer: takes one command, folds a stream of operand
// words into an accumulator through the SIMD alu, then offers the result.
// Optional build macro ALU_SEQ_SATFLAG_EN adds the sticky per-byte
// saturation flag output res_sat.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int LEN_W = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_width,
    input  logic             cmd_sat,
    input  logic [31:0]      cmd_init,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data
`ifdef ALU_SEQ_SATFLAG_EN
    ,
    output logic [3:0]       res_sat
`endif
);

    state_t           r_state;
    state_t           w_nextState;
    logic [31:0]      r_acc;
    logic [LEN_W-1:0] r_remaining;
    logic [1:0]       r_width;
    logic             r_sat;
    logic [31:0]      w_aluOut;
    logic             w_cmdFire;
    logic             w_inFire;

    alu_seq_alu u_alu (
        .i_a     (r_acc),
        .i_b     (in_data),
        .i_width (r_width),
        .i_sat   (r_sat),
        .o_c     (w_aluOut)
    );

    assign w_cmdFire = cmd_valid & cmd_ready;
    assign w_inFire  = in_valid & in_ready;
    assign res_data  = res_valid ? r_acc : 32'd0;

    // State register; reset returns to IDLE from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs; all ready/valid outputs are held
    // low while reset is asserted so nothing handshakes on that cycle.
    always_comb begin
        w_nextState = r_state;
        cmd_ready   = 1'b0;
        in_ready    = 1'b0;
        res_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_nextState = (cmd_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid && (r_remaining == LEN_W'(1))) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        if (rst) begin
            cmd_ready = 1'b0;
            in_ready  = 1'b0;
            res_valid = 1'b0;
        end
    end

    // Accumulator, beat counter and latched command fields. The two fire
    // conditions belong to different states so they never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= 32'd0;
            r_remaining <= '0;
            r_width     <= 2'b00;
            r_sat       <= 1'b0;
        end else if (w_cmdFire) begin
            r_acc       <= cmd_init;
            r_remaining <= cmd_len;
            r_width     <= cmd_width;
            r_sat       <= cmd_sat;
        end else if (w_inFire) begin
            r_acc       <= w_aluOut;
            r_remaining <= r_remaining - LEN_W'(1);
        end
    end

`ifdef ALU_SEQ_SATFLAG_EN
    logic [31:0] w_wrapSum;
    logic [3:0]  w_byteDiff;
    logic [3:0]  w_laneFlag;
    logic [3:0]  r_satFlag;

    assign w_wrapSum = wrapAdd(r_acc, in_data, r_width);
    assign res_sat   = res_valid ? r_satFlag : 4'd0;

    // A clamped lane is one where the alu output differs from the plain
    // wrapped sum; widen each lane's verdict to all of its bytes.
    always_comb begin
        w_byteDiff = 4'd0;
        w_laneFlag = 4'd0;
        for (int i = 0; i < 4; i++) begin
            w_byteDiff[i] = (w_aluOut[i*8 +: 8] != w_wrapSum[i*8 +: 8]);
        end
        if (r_sat) begin
            case (r_width)
                W8:      w_laneFlag = w_byteDiff;
                W16:     w_laneFlag = {{2{|w_byteDiff[3:2]}}, {2{|w_byteDiff[1:0]}}};
                default: w_laneFlag = {4{|w_byteDiff}};
            endcase
        end
    end

    // Sticky flags: cleared per command, accumulated on every beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_satFlag <= 4'd0;
        end else if (w_cmdFire) begin
            r_satFlag <= 4'd0;
        end else if (w_inFire) begin
            r_satFlag <= r_satFlag | w_laneFlag;
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq with hand-computed expected results.
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_width;
    logic        cmd_sat;
    logic [31:0] cmd_init;
    logic [7:0]  cmd_len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
`ifdef ALU_SEQ_SATFLAG_EN
    logic [3:0]  res_sat;
`endif

    int errCount;
    int checkCount;
    logic noiseCmd;

    alu_seq #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_width (cmd_width),
        .cmd_sat   (cmd_sat),
        .cmd_init  (cmd_init),
        .cmd_len   (cmd_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
`ifdef ALU_SEQ_SATFLAG_EN
        ,
        .res_sat   (res_sat)
`endif
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a stuck handshake can never hang the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison and report it if it does not match
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h required 0x%08h", tag, observed, expected);
        end
    endtask

    // Offer one command once cmd_ready is seen, bounded wait
    task automatic applyStimulus(input logic [1:0] w, input logic s, input logic [31:0] init, input logic [7:0] len);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cmdReady", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_width = w;
        cmd_sat   = s;
        cmd_init  = init;
        cmd_len   = len;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_init  = $urandom;
        cmd_len   = 8'd7;
    endtask

    // Send one operand beat after 'gap' idle cycles carrying junk data
    task automatic sendBeat(input logic [31:0] d, input int gap);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            in_data   = $urandom;
            cmd_valid = noiseCmd;
            if (noiseCmd) begin
                checkOutput("cmdBlockedRun", {31'd0, cmd_ready}, 32'd0);
            end
        end
        @(negedge clk);
        checkOutput("inReady", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    // Expect the result the cycle after the last beat, hold it 'hold' cycles
    // under backpressure, then consume it
    task automatic getResult(input string tag, input logic [31:0] expData, input logic [3:0] expSat, input int hold);
        int n;
        @(negedge clk);
        checkOutput({tag, "_latency"}, {31'd0, res_valid}, 32'd1);
        checkOutput({tag, "_inReadyDone"}, {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < hold; i++) begin
            checkOutput({tag, "_holdValid"}, {31'd0, res_valid}, 32'd1);
            checkOutput({tag, "_holdData"}, res_data, expData);
            if (noiseCmd) begin
                checkOutput({tag, "_cmdBlockedDone"}, {31'd0, cmd_ready}, 32'd0);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checkOutput(tag, res_data, expData);
`ifdef ALU_SEQ_SATFLAG_EN
        checkOutput({tag, "_sat"}, {28'd0, res_sat}, {28'd0, expSat});
`endif
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    initial begin
        errCount   = 0;
        checkCount = 0;
        noiseCmd   = 1'b0;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_width  = 2'b00;
        cmd_sat    = 1'b0;
        cmd_init   = 32'd0;
        cmd_len    = 8'd0;
        in_valid   = 1'b0;
        in_data    = 32'd0;
        res_ready  = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rstCmdReady", {31'd0, cmd_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("postRstCmdReady", {31'd0, cmd_ready}, 32'd1);
        checkOutput("postRstInReady", {31'd0, in_ready}, 32'd0);
        checkOutput("postRstResValid", {31'd0, res_valid}, 32'd0);
        checkOutput("postRstResData", res_data, 32'd0);

        // Operand traffic while idle must be ignored
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h5555_5555;
        #1;
        checkOutput("idleInReady", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;

        // 8-bit wrap
        applyStimulus(2'b00, 1'b0, 32'h0000_0000, 8'd2);
        sendBeat(32'h7F7F_7F7F, 0);
        sendBeat(32'h0101_0101, 0);
        getResult("wrap8", 32'h8080_8080, 4'h0, 0);

        // 8-bit saturate
        applyStimulus(2'b00, 1'b1, 32'h0000_0000, 8'd2);
        sendBeat(32'h7F7F_7F7F, 0);
        sendBeat(32'h0101_0101, 0);
        getResult("sat8", 32'h7F7F_7F7F, 4'hF, 0);

        // 8-bit saturate, only the top lane overflows
        applyStimulus(2'b00, 1'b1, 32'h7F80_0102, 8'd1);
        sendBeat(32'h0101_0101, 0);
        getResult("sat8Partial", 32'h7F81_0203, 4'h8, 0);

        // Lane isolation at 16 and 32 bits, and reserved width code
        applyStimulus(2'b01, 1'b0, 32'h0000_FFFF, 8'd1);
        sendBeat(32'h0000_0001, 0);
        getResult("iso16", 32'h0000_0000, 4'h0, 0);

        applyStimulus(2'b10, 1'b0, 32'h0000_FFFF, 8'd1);
        sendBeat(32'h0000_0001, 0);
        getResult("iso32", 32'h0001_0000, 4'h0, 0);

        applyStimulus(2'b11, 1'b0, 32'h0000_FFFF, 8'd1);
        sendBeat(32'h0000_0001, 0);
        getResult("width11", 32'h0001_0000, 4'h0, 0);

        // 16-bit saturate: upper lane to negative limit, lower to positive
        applyStimulus(2'b01, 1'b1, 32'h8000_7FFF, 8'd1);
        sendBeat(32'hFFFF_0001, 0);
        getResult("sat16", 32'h8000_7FFF, 4'hF, 0);

        // 32-bit saturate
        applyStimulus(2'b10, 1'b1, 32'h7FFF_FFF0, 8'd1);
        sendBeat(32'h0000_0020, 0);
        getResult("sat32", 32'h7FFF_FFFF, 4'hF, 0);

        // Zero-length command returns the initial value next cycle
        applyStimulus(2'b00, 1'b0, 32'hDEAD_BEEF, 8'd0);
        getResult("zeroLen", 32'hDEAD_BEEF, 4'h0, 0);

        // Gapped beats, command noise during RUN/DONE, result backpressure
        applyStimulus(2'b00, 1'b0, 32'h0102_0304, 8'd3);
        noiseCmd = 1'b1;
        sendBeat(32'h1010_1010, 2);
        sendBeat(32'h0101_0101, 0);
        sendBeat(32'hF0F0_F0F0, 3);
        cmd_valid = 1'b1;
        getResult("gapped", 32'h0203_0405, 4'h0, 5);
        noiseCmd  = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("idleAfterNoise", {31'd0, cmd_ready}, 32'd1);

        // Reset in the middle of a run
        applyStimulus(2'b00, 1'b0, 32'h0000_0000, 8'd3);
        sendBeat(32'h1111_1111, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midRstCmdReady", {31'd0, cmd_ready}, 32'd0);
        checkOutput("midRstInReady", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("midRstResValid", {31'd0, res_valid}, 32'd0);
        checkOutput("midRstResData", res_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("afterRstCmdReady", {31'd0, cmd_ready}, 32'd1);
        checkOutput("afterRstInReady", {31'd0, in_ready}, 32'd0);
        checkOutput("afterRstResValid", {31'd0, res_valid}, 32'd0);
        applyStimulus(2'b00, 1'b0, 32'h0000_0005, 8'd1);
        sendBeat(32'h0000_0003, 0);
        getResult("afterRst", 32'h0000_0008, 4'h0, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
